// File: rtl/msx_bus_pkg.sv
// msx_bus_pkg: shared FSM state encoding and default timing for the MSX bus synchronizer.
package msx_bus_pkg;
   typedef enum logic [2:0] {IDLE, SETTLE, STROBE, HOLD, RECOVER} state_e;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_SETTLE_CYCLES = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchronizer with configurable width, depth and reset level.
module sync_ff #(
   parameter int           W       = 1,
   parameter int           DEPTH   = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] ff_q [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) ff_q[i] <= RST_VAL;
      end else begin
         ff_q[0] <= d;
         for (int i = 1; i < DEPTH; i++) ff_q[i] <= ff_q[i-1];
      end
   end

   assign q = ff_q[DEPTH-1];
endmodule

// File: rtl/msx_bus_sync.sv
// msx_bus_sync: synchronizes raw MSX cartridge strobes, captures the access and
// issues a single enable per access, optionally driving read data back onto the bus.
module msx_bus_sync
   import msx_bus_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] bus_addr,
   input  logic [7:0]  bus_din,
   input  logic        bus_rd_n,
   input  logic        bus_wr_n,
   input  logic        bus_sltsl_n,
   output logic [15:0] addr,
   output logic [7:0]  cdin,
   output logic        rd_n,
   output logic        wr_n,
   output logic        sltsl_n,
   output logic        enable,
   input  logic        busreq,
   input  logic [7:0]  cdout,
   output logic [7:0]  bus_dout,
   output logic        bus_oe
);
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  cdin_q, cdin_d, dout_q, dout_d;
   logic        rd_n_q, rd_n_d, wr_n_q, wr_n_d, sl_n_q, sl_n_d;
   logic        oe_q, oe_d, req_q, req_d;
   logic        raw_stb, stb_s, sltsl_s;

   assign raw_stb = ~bus_rd_n | ~bus_wr_n;

   sync_ff #(.W(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_stb_sync (
      .clk(clk), .reset_n(reset_n), .d(raw_stb), .q(stb_s));
   sync_ff #(.W(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sltsl_sync (
      .clk(clk), .reset_n(reset_n), .d(bus_sltsl_n), .q(sltsl_s));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      cdin_d  = cdin_q;
      rd_n_d  = rd_n_q;
      wr_n_d  = wr_n_q;
      sl_n_d  = sl_n_q;
      dout_d  = dout_q;
      oe_d    = 1'b0;
      req_d   = (state_q == STROBE) & busreq;
      case (state_q)
         IDLE: if (stb_s) begin
            state_d = SETTLE;
            cnt_d   = 4'(SETTLE_CYCLES - 1);
         end
         // A strobe already gone from the raw bus at capture time is a glitch too
         SETTLE: if (!stb_s) state_d = IDLE;
         else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
         else if (raw_stb) begin
            state_d = STROBE;
            addr_d  = bus_addr;
            cdin_d  = bus_din;
            wr_n_d  = bus_wr_n;
            rd_n_d  = bus_rd_n | ~bus_wr_n;
            sl_n_d  = sltsl_s;
         end
         else state_d = IDLE;
         STROBE: state_d = HOLD;
         HOLD: if (!stb_s) begin
            state_d = RECOVER;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            sl_n_d  = 1'b1;
         end else begin
            oe_d   = oe_q | (req_q & ~rd_n_q);
            dout_d = (req_q & ~rd_n_q) ? cdout : dout_q;
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         cdin_q  <= '0;
         dout_q  <= '0;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         sl_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         cdin_q  <= cdin_d;
         dout_q  <= dout_d;
         rd_n_q  <= rd_n_d;
         wr_n_q  <= wr_n_d;
         sl_n_q  <= sl_n_d;
         oe_q    <= oe_d;
         req_q   <= req_d;
      end
   end

   assign addr     = addr_q;
   assign cdin     = cdin_q;
   assign rd_n     = rd_n_q;
   assign wr_n     = wr_n_q;
   assign sltsl_n  = sl_n_q;
   assign enable   = (state_q == STROBE);
   assign bus_dout = dout_q;
   assign bus_oe   = oe_q;
endmodule

// File: tb/tb_msx_bus_sync.sv
// tb_msx_bus_sync: directed self-checking bench for msx_bus_sync with default parameters.
module tb_msx_bus_sync;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [15:0] bus_addr = '0;
   logic [7:0]  bus_din = '0, cdout = '0;
   logic        bus_rd_n = 1'b1, bus_wr_n = 1'b1, bus_sltsl_n = 1'b1, busreq = 1'b0;
   logic [15:0] addr;
   logic [7:0]  cdin, bus_dout;
   logic        rd_n, wr_n, sltsl_n, enable, bus_oe;
   int          vectors = 0, miscompares = 0;
   int          t, n_en, en_at;
   logic        oe_seen;

   always #5 clk = ~clk;

   msx_bus_sync dut (
      .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_din(bus_din),
      .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_sltsl_n(bus_sltsl_n),
      .addr(addr), .cdin(cdin), .rd_n(rd_n), .wr_n(wr_n), .sltsl_n(sltsl_n),
      .enable(enable), .busreq(busreq), .cdout(cdout), .bus_dout(bus_dout), .bus_oe(bus_oe));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      t = 0;
      n_en = 0;
      en_at = 0;
      oe_seen = 1'b0;
   endtask

   // t counts edges since the strobe was driven; edge t is the t-th edge sampling it
   task automatic step();
      @(posedge clk);
      #1;
      t++;
      if (enable === 1'b1) begin
         n_en++;
         en_at = t;
      end
      if (bus_oe !== 1'b0) oe_seen = 1'b1;
   endtask

   initial begin
      clr();
      step();
      chk("rst_addr", addr, 16'h0000);
      chk("rst_cdin", 16'(cdin), 16'h0000);
      chk("rst_rd_n", 16'(rd_n), 16'h1);
      chk("rst_wr_n", 16'(wr_n), 16'h1);
      chk("rst_sltsl_n", 16'(sltsl_n), 16'h1);
      chk("rst_enable", 16'(enable), 16'h0);
      chk("rst_bus_oe", 16'(bus_oe), 16'h0);
      chk("rst_bus_dout", 16'(bus_dout), 16'h0000);
      @(negedge clk) reset_n = 1'b1;
      repeat (3) step();

      // write, 10 cycles low
      bus_addr = 16'hFFFF; bus_din = 8'hA5; bus_sltsl_n = 1'b0; bus_wr_n = 1'b0; clr();
      repeat (4) step();
      chk("wr_pre_enable", 16'(enable), 16'h0);
      step();
      chk("wr_enable_edge5", 16'(enable), 16'h1);
      chk("wr_wr_n", 16'(wr_n), 16'h0);
      chk("wr_rd_n", 16'(rd_n), 16'h1);
      chk("wr_sltsl_n", 16'(sltsl_n), 16'h0);
      chk("wr_addr", addr, 16'hFFFF);
      chk("wr_cdin", 16'(cdin), 16'h00A5);
      repeat (5) step();
      chk("wr_hold_wr_n", 16'(wr_n), 16'h0);
      bus_wr_n = 1'b1; bus_sltsl_n = 1'b1;
      repeat (3) step();
      chk("wr_recover_wr_n", 16'(wr_n), 16'h1);
      chk("wr_recover_sltsl_n", 16'(sltsl_n), 16'h1);
      repeat (3) step();
      chk("wr_enable_count", 16'(n_en), 16'd1);
      chk("wr_enable_at", 16'(en_at), 16'd5);
      chk("wr_bus_oe_never", 16'(oe_seen), 16'h0);
      chk("wr_addr_held", addr, 16'hFFFF);

      // read with busreq, 12 cycles low
      bus_addr = 16'h1234; bus_rd_n = 1'b0; clr();
      repeat (5) step();
      chk("rd_enable", 16'(enable), 16'h1);
      chk("rd_rd_n", 16'(rd_n), 16'h0);
      chk("rd_wr_n", 16'(wr_n), 16'h1);
      busreq = 1'b1; cdout = 8'h5A;
      step();
      chk("rd_oe_first_hold", 16'(bus_oe), 16'h0);
      step();
      busreq = 1'b0; cdout = 8'hFF;
      chk("rd_oe_second_hold", 16'(bus_oe), 16'h1);
      chk("rd_dout", 16'(bus_dout), 16'h005A);
      repeat (5) step();
      bus_rd_n = 1'b1;
      repeat (2) step();
      chk("rd_oe_still_hold", 16'(bus_oe), 16'h1);
      chk("rd_dout_held", 16'(bus_dout), 16'h005A);
      step();
      chk("rd_oe_drop", 16'(bus_oe), 16'h0);
      chk("rd_recover_rd_n", 16'(rd_n), 16'h1);
      repeat (3) step();
      chk("rd_enable_count", 16'(n_en), 16'd1);

      // glitch, 3 cycles low
      bus_rd_n = 1'b0; clr();
      repeat (3) step();
      bus_rd_n = 1'b1;
      repeat (7) step();
      chk("gl_enable_count", 16'(n_en), 16'd0);
      chk("gl_bus_oe_never", 16'(oe_seen), 16'h0);
      chk("gl_rd_n", 16'(rd_n), 16'h1);

      // back-to-back reads with one high cycle between
      bus_addr = 16'h1111; bus_rd_n = 1'b0; clr();
      repeat (5) step();
      chk("b2b_enable1", 16'(enable), 16'h1);
      chk("b2b_addr1", addr, 16'h1111);
      step();
      bus_rd_n = 1'b1;
      step();
      bus_rd_n = 1'b0; bus_addr = 16'h2222;
      repeat (2) step();
      chk("b2b_recover_rd_n", 16'(rd_n), 16'h1);
      chk("b2b_recover_addr", addr, 16'h1111);
      repeat (4) step();
      chk("b2b_enable2", 16'(enable), 16'h1);
      chk("b2b_addr2", addr, 16'h2222);
      repeat (2) step();
      bus_rd_n = 1'b1;
      repeat (6) step();
      chk("b2b_enable_count", 16'(n_en), 16'd2);

      // reset mid-HOLD with bus_oe high
      bus_addr = 16'hBEEF; bus_rd_n = 1'b0; busreq = 1'b1; cdout = 8'h3C; clr();
      repeat (7) step();
      chk("rh_oe_before", 16'(bus_oe), 16'h1);
      chk("rh_dout_before", 16'(bus_dout), 16'h003C);
      #2 reset_n = 1'b0;
      #1;
      chk("rh_oe_async", 16'(bus_oe), 16'h0);
      chk("rh_rd_n_async", 16'(rd_n), 16'h1);
      chk("rh_enable_async", 16'(enable), 16'h0);
      bus_rd_n = 1'b1; busreq = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      clr();
      repeat (8) step();
      chk("rh_no_enable", 16'(n_en), 16'd0);
      chk("rh_no_oe", 16'(oe_seen), 16'h0);

      // both strobes low: write wins, no bus drive even with busreq
      bus_addr = 16'h4000; bus_din = 8'h77; bus_rd_n = 1'b0; bus_wr_n = 1'b0;
      busreq = 1'b1; cdout = 8'h99; clr();
      repeat (5) step();
      chk("both_enable", 16'(enable), 16'h1);
      chk("both_wr_n", 16'(wr_n), 16'h0);
      chk("both_rd_n", 16'(rd_n), 16'h1);
      chk("both_addr", addr, 16'h4000);
      chk("both_cdin", 16'(cdin), 16'h0077);
      repeat (5) step();
      bus_rd_n = 1'b1; bus_wr_n = 1'b1; busreq = 1'b0;
      repeat (6) step();
      chk("both_enable_count", 16'(n_en), 16'd1);
      chk("both_bus_oe_never", 16'(oe_seen), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/msx_bus_sync.md
MSX_BUS_SYNC -- requirements
Module: msx_bus_sync

Interface
REQ-001 The block SHALL run on one clock and SHALL use an asynchronous, active-low reset; ports clk and reset_n.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for the bus strobes.
REQ-003 Parameter SETTLE_CYCLES, default 2, range 1-15: cycles of address/data settling after a synchronized strobe.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- bus_addr  in  16  raw cartridge address
- bus_din  in  8  raw cartridge data, Z80 to cartridge
- bus_rd_n  in  1  raw RD strobe
- bus_wr_n  in  1  raw WR strobe
- bus_sltsl_n  in  1  raw slot select
- addr  out  16  captured address
- cdin  out  8  captured write data
- rd_n  out  1  qualified read
- wr_n  out  1  qualified write
- sltsl_n  out  1  qualified slot select
- enable  out  1  one-cycle access strobe to downstream slot logic
- busreq  in  1  downstream request to drive the bus, registered on the enable cycle
- cdout  in  8  downstream read data
- bus_dout  out  8  data driven to the cartridge bus
- bus_oe  out  1  data-bus output enable / transceiver direction

Function
REQ-005 The raw strobe SHALL be (~bus_rd_n | ~bus_wr_n), passed through SYNC_STAGES flip-flops; bus_sltsl_n SHALL be synchronized identically.
REQ-006 The FSM states SHALL be IDLE, SETTLE, STROBE, HOLD and RECOVER.
REQ-007 IDLE to SETTLE SHALL occur when the synchronized strobe is 1; the settle counter SHALL load SETTLE_CYCLES-1.
REQ-008 In SETTLE, the counter SHALL decrement each cycle; at 0 the FSM SHALL enter STROBE.
REQ-009 If the synchronized strobe returns to 0 during SETTLE, the FSM SHALL return to IDLE with no enable pulse (glitch abort).
REQ-010 On the edge entering STROBE, addr, cdin, rd_n, wr_n and sltsl_n SHALL be captured from the raw bus and held constant until RECOVER.
REQ-011 If both raw strobes are low at capture, wr_n SHALL be 0 and rd_n SHALL be 1 (write priority).
REQ-012 enable SHALL be 1 for exactly one cycle, in STROBE; the FSM SHALL then enter HOLD.
REQ-013 Latency: enable SHALL rise SYNC_STAGES+SETTLE_CYCLES+1 rising edges after the first edge that samples a raw strobe low; the default is 5.
REQ-014 In the first HOLD cycle, if busreq=1 and rd_n=0, bus_dout SHALL load cdout and bus_oe SHALL go 1 on the next edge.
REQ-015 bus_oe SHALL NOT assert for writes.
REQ-016 HOLD SHALL persist while the synchronized strobe is 1.
REQ-017 On strobe release, the FSM SHALL enter RECOVER and bus_oe SHALL drop on that same edge.
REQ-018 RECOVER SHALL last one cycle.
REQ-019 In RECOVER, rd_n, wr_n and sltsl_n SHALL return to 1; then the FSM SHALL return to IDLE.
REQ-020 A new strobe during RECOVER SHALL be handled from IDLE on the following cycle; the access SHALL NOT be lost and SHALL NOT be double-counted.
REQ-021 Exactly one enable pulse SHALL occur per raw strobe low period, regardless of its length.
REQ-022 bus_oe SHALL never be 1 outside HOLD/RECOVER entry.

Reset
REQ-023 On reset_n=0 (asynchronous), the block SHALL reset as follows:
- state=IDLE
- enable=0, bus_oe=0, bus_dout=8'h00
- rd_n=1, wr_n=1, sltsl_n=1
- addr=16'h0000, cdin=8'h00
- synchronizer flops to the idle level
- settle counter=0
REQ-024 Reset asserted mid-access SHALL release the bus (bus_oe=0) immediately, without waiting for a clock.

Structure
REQ-025 A shared package msx_bus_pkg SHALL hold the FSM state enum and the default SYNC_STAGES/SETTLE_CYCLES constants.
REQ-026 The synchronizer SHALL be a sub-module sync_ff (parameterised width and depth, async reset value) instantiated for the strobe and sltsl_n.

Verification
REQ-027 Write: bus_addr=16'hFFFF, bus_din=8'hA5, bus_sltsl_n=0, bus_wr_n low for 10 cycles -> one enable on edge 5, wr_n=0, addr=16'hFFFF, cdin=8'hA5, bus_oe stays 0.
REQ-028 Read with busreq: bus_rd_n low 12 cycles, busreq=1 and cdout=8'h5A on the enable cycle -> bus_oe=1, bus_dout=8'h5A from the second HOLD cycle, drop on the edge the synchronized strobe clears.
REQ-029 Glitch: bus_rd_n low for 3 cycles with defaults -> FSM aborts in SETTLE, enable never asserts, bus_oe=0.
REQ-030 Back-to-back: two reads separated by 1 high cycle -> exactly two enable pulses, addr updated between them, rd_n high during RECOVER.
REQ-031 Reset mid-HOLD with bus_oe=1 -> bus_oe=0 and rd_n=1 without a clock edge; after release, state=IDLE and no enable pulse until a new strobe.
REQ-032 Both strobes low, bus_addr=16'h4000 -> wr_n=0, rd_n=1, enable once, bus_oe=0.
